// File: rtl/dsp_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_seq_pkg
// Description : Shared types and constants for the dsp_mac_seq sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

  // Slice OPMODE encodings: X mux in [1:0], Z mux in [3:2]
  localparam logic [7:0] OPM_FIRST     = 8'h01;
  localparam logic [7:0] OPM_ACC       = 8'h09;
  localparam logic [7:0] OPM_HOLD      = 8'h08;
  localparam logic [7:0] OPM_BIAS      = 8'h0D;
  localparam logic [7:0] OPM_BIAS_ONLY = 8'h0C;

  localparam int DSP_LAT = 3;

endpackage
`default_nettype wire

// File: rtl/dsp_mac_seq_tagpipe.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_seq_tagpipe
// Description : Two-stage delay line for {valid, first} element tags.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_seq_tagpipe
  import dsp_mac_seq_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  tag_t push,
  output tag_t stage1,
  output logic stage2_valid
);

  tag_t stage1_q, stage1_d;
  logic stage2_valid_q, stage2_valid_d;

  // The first flag only steers the OPMODE in stage 1, so stage 2 carries valid alone.
  always_comb begin
    stage1_d       = push;
    stage2_valid_d = stage1_q.valid;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage1_q       <= '0;
      stage2_valid_q <= 1'b0;
    end else begin
      stage1_q       <= stage1_d;
      stage2_valid_q <= stage2_valid_d;
    end
  end

  assign stage1       = stage1_q;
  assign stage2_valid = stage2_valid_q;

endmodule
`default_nettype wire

// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_seq
// Description : Streams signed operand pairs through one dsp slice as a MAC and
//               returns the 48-bit dot product. DSP_MAC_SEQ_BIAS_EN adds a bias.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_seq
  import dsp_mac_seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef DSP_MAC_SEQ_BIAS_EN
  input  logic [47:0]      bias,
`endif
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [47:0]      dsp_c,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  localparam logic [1:0]       DRAIN_LOAD = 2'(DSP_LAT - 2);
  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
`ifdef DSP_MAC_SEQ_BIAS_EN
  localparam logic [7:0]       OPM_FIRST_SEL = OPM_BIAS;
`else
  localparam logic [7:0]       OPM_FIRST_SEL = OPM_FIRST;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [1:0]       drain_q, drain_d;
`ifdef DSP_MAC_SEQ_BIAS_EN
  logic [47:0]      bias_q, bias_d;
  logic [1:0]       bo_q, bo_d;
`else
  logic             empty_q, empty_d;
`endif

  logic w_accept;
  logic w_last;
  tag_t w_push;
  tag_t w_stage1;
  logic w_stage2_valid;

  assign in_ready = !RST && (state_q == RUN) && (count_q < len_q);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (count_q + ONE) == len_q;

  dsp_mac_seq_tagpipe u_tagpipe (
    .CLK          (CLK),
    .RST          (RST),
    .push         (w_push),
    .stage1       (w_stage1),
    .stage2_valid (w_stage2_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      drain_q <= '0;
`ifdef DSP_MAC_SEQ_BIAS_EN
      bias_q  <= '0;
      bo_q    <= '0;
`else
      empty_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      drain_q <= drain_d;
`ifdef DSP_MAC_SEQ_BIAS_EN
      bias_q  <= bias_d;
      bo_q    <= bo_d;
`else
      empty_q <= empty_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    drain_d = drain_q;
`ifdef DSP_MAC_SEQ_BIAS_EN
    bias_d  = bias_q;
    bo_d    = bo_q;
`else
    empty_d = empty_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          count_d = '0;
`ifdef DSP_MAC_SEQ_BIAS_EN
          bias_d  = bias;
          // Empty job still routes the bias through P: one OPMODE slot, one CEP slot
          if (len == '0) begin
            state_d = DONE;
            bo_d    = 2'd2;
          end else begin
            state_d = RUN;
          end
`else
          empty_d = (len == '0);
          state_d = (len == '0) ? DONE : RUN;
`endif
        end
      end
      RUN: begin
        if (w_accept) begin
          count_d = count_q + ONE;
          if (w_last) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      DONE: begin
`ifdef DSP_MAC_SEQ_BIAS_EN
        if (bo_q != '0) begin
          bo_d = bo_q - 2'd1;
        end else if (res_ready) begin
          state_d = IDLE;
        end
`else
        if (res_ready) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    dsp_a        = in_a;
    dsp_b        = in_b;
    dsp_cea      = w_accept;
    dsp_ceb      = w_accept;
    w_push.valid = w_accept;
    w_push.first = (count_q == '0);
    dsp_cem      = !RST && w_stage1.valid;
    dsp_cep      = !RST && w_stage2_valid;
    dsp_ceopmode = 1'b1;
    dsp_rst      = RST;
    if (RST || !w_stage1.valid) begin
      dsp_opmode = OPM_HOLD;
    end else if (w_stage1.first) begin
      dsp_opmode = OPM_FIRST_SEL;
    end else begin
      dsp_opmode = OPM_ACC;
    end
`ifdef DSP_MAC_SEQ_BIAS_EN
    dsp_c = bias_q;
    if (bo_q == 2'd2) begin
      dsp_opmode = OPM_BIAS_ONLY;
    end
    if (!RST && (bo_q == 2'd1)) begin
      dsp_cep = 1'b1;
    end
    res_valid = (state_q == DONE) && (bo_q == '0);
    res_data  = dsp_p;
`else
    dsp_c     = '0;
    res_valid = (state_q == DONE);
    // P still holds the previous job after an empty job, so mask it
    res_data  = empty_q ? 48'd0 : dsp_p;
`endif
  end

endmodule
`default_nettype wire
